// File: rtl/idecoder_pipe_pkg.sv
// Shared RV32I decode constants, the decoded-entry struct and the ALU funct helper.
// Pure declarations: no latency, no backpressure.
package idecoder_pipe_pkg;

    localparam int INST_WIDTH      = 32;
    localparam int OPCODE_WIDTH    = 7;
    localparam int IMM_WIDTH       = 32;
    localparam int INST_TYPE_WIDTH = 4;
    localparam int REG_WIDTH       = 5;
    localparam int FUNCT_WIDTH     = 5;

    localparam logic [OPCODE_WIDTH-1:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_JAL     = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_JALR    = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_INT_IMM = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_INT_REG = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_FENCE   = 7'b0001111;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_SYSTEM  = 7'b1110011;

    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_IMM     = 4'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_AUIPC   = 4'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JAL     = 4'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JALR    = 4'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_BRANCH  = 4'd4;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_LOAD    = 4'd5;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_STORE   = 4'd6;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_IMM = 4'd7;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_REG = 4'd8;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_FENCE   = 4'd9;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_SYSTEM  = 4'd10;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_ILLEGAL = 4'd11;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_NONE       = 5'd0;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD        = 5'd1;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB        = 5'd2;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT        = 5'd3;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLTU       = 5'd4;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_XOR        = 5'd5;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR         = 5'd6;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND        = 5'd7;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL        = 5'd8;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL        = 5'd9;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRA        = 5'd10;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_EQ         = 5'd11;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_NEQ        = 5'd12;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_LT         = 5'd13;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_GTE        = 5'd14;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_LTU        = 5'd15;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_GTEU       = 5'd16;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_BYTE   = 5'd17;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_HWORD  = 5'd18;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_WORD   = 5'd19;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_BYTEU  = 5'd20;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_HWORDU = 5'd21;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ECALL      = 5'd22;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_EBREAK     = 5'd23;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]    opcode;
        logic [IMM_WIDTH-1:0]       imm;
        logic [INST_TYPE_WIDTH-1:0] inst_type;
        logic [REG_WIDTH-1:0]       rd;
        logic [REG_WIDTH-1:0]       rs1;
        logic [REG_WIDTH-1:0]       rs2;
        logic [FUNCT_WIDTH-1:0]     funct;
        logic                       illegal;
    } dec_t;

    // alt selects SUB/SRA; callers only raise it where the encoding allows.
    function automatic logic [FUNCT_WIDTH-1:0] alu_funct(input logic [2:0] f3, input logic alt);
        logic [FUNCT_WIDTH-1:0] f;
        case (f3)
            3'd0:    f = alt ? FUNCT_SUB : FUNCT_ADD;
            3'd1:    f = FUNCT_SLL;
            3'd2:    f = FUNCT_SLT;
            3'd3:    f = FUNCT_SLTU;
            3'd4:    f = FUNCT_XOR;
            3'd5:    f = alt ? FUNCT_SRA : FUNCT_SRL;
            3'd6:    f = FUNCT_OR;
            default: f = FUNCT_AND;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/idecoder_pipe_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle with flush.
// slave is the decode stage, master is whoever drives fetch and consumes decode.
interface idecoder_pipe_if
    import idecoder_pipe_pkg::*;
#(
    parameter int PC_WIDTH = 32
);
    logic                       flush;
    logic                       inst_valid;
    logic                       inst_ready;
    logic [INST_WIDTH-1:0]      inst;
    logic [PC_WIDTH-1:0]        pc_in;
    logic                       dec_valid;
    logic                       dec_ready;
    logic [OPCODE_WIDTH-1:0]    opcode;
    logic [IMM_WIDTH-1:0]       imm;
    logic [INST_TYPE_WIDTH-1:0] inst_type;
    logic [REG_WIDTH-1:0]       rd;
    logic [REG_WIDTH-1:0]       rs1;
    logic [REG_WIDTH-1:0]       rs2;
    logic [FUNCT_WIDTH-1:0]     funct;
    logic                       illegal;
    logic [PC_WIDTH-1:0]        pc_out;

    modport slave (
        input  flush, inst_valid, inst, pc_in, dec_ready,
        output inst_ready, dec_valid, opcode, imm, inst_type, rd, rs1, rs2, funct, illegal, pc_out
    );

    modport master (
        output flush, inst_valid, inst, pc_in, dec_ready,
        input  inst_ready, dec_valid, opcode, imm, inst_type, rd, rs1, rs2, funct, illegal, pc_out
    );
endinterface

// File: rtl/idecoder_pipe_decode.sv
// Combinational RV32I field/format decode with illegal-encoding detection.
// Zero latency, no handshake; illegal encodings zero every field except opcode.
module rv32i_decode_logic
    import idecoder_pipe_pkg::*;
(
    input  logic [INST_WIDTH-1:0] inst,
    output dec_t                  dec
);
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [IMM_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic                 bad;

    always_comb begin
        f3     = inst[14:12];
        f7     = inst[31:25];
        imm_i  = {{20{inst[31]}}, inst[31:20]};
        imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u  = {inst[31:12], 12'b0};
        imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_sh = {27'b0, inst[24:20]};
        bad    = 1'b0;
        dec    = '0;
        dec.opcode = inst[6:0];

        case (inst[6:0])
            OPCODE_LUI: begin
                dec.inst_type = INST_TYPE_IMM;
                dec.imm       = imm_u;
                dec.rd        = inst[11:7];
            end
            OPCODE_AUIPC: begin
                dec.inst_type = INST_TYPE_AUIPC;
                dec.imm       = imm_u;
                dec.rd        = inst[11:7];
            end
            OPCODE_JAL: begin
                dec.inst_type = INST_TYPE_JAL;
                dec.imm       = imm_j;
                dec.rd        = inst[11:7];
            end
            OPCODE_JALR: begin
                dec.inst_type = INST_TYPE_JALR;
                dec.imm       = imm_i;
                dec.rd        = inst[11:7];
                dec.rs1       = inst[19:15];
                bad           = (f3 != 3'd0);
            end
            OPCODE_BRANCH: begin
                dec.inst_type = INST_TYPE_BRANCH;
                dec.imm       = imm_b;
                dec.rs1       = inst[19:15];
                dec.rs2       = inst[24:20];
                case (f3)
                    3'd0:    dec.funct = FUNCT_EQ;
                    3'd1:    dec.funct = FUNCT_NEQ;
                    3'd4:    dec.funct = FUNCT_LT;
                    3'd5:    dec.funct = FUNCT_GTE;
                    3'd6:    dec.funct = FUNCT_LTU;
                    3'd7:    dec.funct = FUNCT_GTEU;
                    default: bad = 1'b1;
                endcase
            end
            OPCODE_LOAD: begin
                dec.inst_type = INST_TYPE_LOAD;
                dec.imm       = imm_i;
                dec.rd        = inst[11:7];
                dec.rs1       = inst[19:15];
                case (f3)
                    3'd0:    dec.funct = FUNCT_MEM_BYTE;
                    3'd1:    dec.funct = FUNCT_MEM_HWORD;
                    3'd2:    dec.funct = FUNCT_MEM_WORD;
                    3'd4:    dec.funct = FUNCT_MEM_BYTEU;
                    3'd5:    dec.funct = FUNCT_MEM_HWORDU;
                    default: bad = 1'b1;
                endcase
            end
            OPCODE_STORE: begin
                dec.inst_type = INST_TYPE_STORE;
                dec.imm       = imm_s;
                dec.rs1       = inst[19:15];
                dec.rs2       = inst[24:20];
                case (f3)
                    3'd0:    dec.funct = FUNCT_MEM_BYTE;
                    3'd1:    dec.funct = FUNCT_MEM_HWORD;
                    3'd2:    dec.funct = FUNCT_MEM_WORD;
                    default: bad = 1'b1;
                endcase
            end
            OPCODE_INT_IMM: begin
                dec.inst_type = INST_TYPE_INT_IMM;
                dec.rd        = inst[11:7];
                dec.rs1       = inst[19:15];
                dec.funct     = alu_funct(f3, (f3 == 3'd5) && f7[5]);
                // Shift forms carry a 5-bit shamt instead of a sign-extended immediate.
                if (f3 == 3'd1) begin
                    dec.imm = imm_sh;
                    bad     = (f7 != 7'd0);
                end else if (f3 == 3'd5) begin
                    dec.imm = imm_sh;
                    bad     = (f7 != 7'd0) && (f7 != 7'd32);
                end else begin
                    dec.imm = imm_i;
                end
            end
            OPCODE_INT_REG: begin
                dec.inst_type = INST_TYPE_INT_REG;
                dec.rd        = inst[11:7];
                dec.rs1       = inst[19:15];
                dec.rs2       = inst[24:20];
                dec.funct     = alu_funct(f3, f7[5]);
                bad = ((f7 != 7'd0) && (f7 != 7'd32)) ||
                      ((f7 == 7'd32) && (f3 != 3'd0) && (f3 != 3'd5));
            end
            OPCODE_FENCE: begin
                dec.inst_type = INST_TYPE_FENCE;
            end
            OPCODE_SYSTEM: begin
                dec.inst_type = INST_TYPE_SYSTEM;
                if (inst == 32'h0000_0073)
                    dec.funct = FUNCT_ECALL;
                else if (inst == 32'h0010_0073)
                    dec.funct = FUNCT_EBREAK;
                else
                    bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            dec.inst_type = INST_TYPE_ILLEGAL;
            dec.imm       = '0;
            dec.rd        = '0;
            dec.rs1       = '0;
            dec.rs2       = '0;
            dec.funct     = FUNCT_NONE;
            dec.illegal   = 1'b1;
        end
    end
endmodule

// File: rtl/idecoder_pipe.sv
// Registered RV32I decode stage: one-cycle latency, full throughput.
// SKID=1 uses a two-entry skid buffer with registered inst_ready; SKID=0 a single register.
module idecoder_pipe
    import idecoder_pipe_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter bit SKID     = 1'b1
)(
    input logic            clk,
    input logic            rst,
    idecoder_pipe_if.slave bus
);
    typedef struct packed {
        dec_t                dec;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    dec_t   dec_new;
    entry_t new_e, main_q, skid_q, main_n, skid_n;
    logic   main_vld, skid_vld, main_vld_n, skid_vld_n;
    logic   rdy_q, accept, drain;

    rv32i_decode_logic u_decode (
        .inst (bus.inst),
        .dec  (dec_new)
    );

    assign new_e = '{dec: dec_new, pc: bus.pc_in};

    // rdy_q stays low through reset so nothing is taken before the first clean edge.
    assign bus.inst_ready = SKID ? rdy_q : (rdy_q & (~main_vld | bus.dec_ready));
    assign accept         = bus.inst_valid & bus.inst_ready & ~bus.flush;
    assign drain          = main_vld & bus.dec_ready;

    always_comb begin
        main_vld_n = main_vld;
        skid_vld_n = skid_vld;
        main_n     = main_q;
        skid_n     = skid_q;
        if (bus.flush) begin
            main_vld_n = 1'b0;
            skid_vld_n = 1'b0;
        end else if (SKID) begin
            // Skid full implies inst_ready low, so accept never coincides with this refill.
            if (drain && skid_vld) begin
                main_n     = skid_q;
                skid_vld_n = 1'b0;
            end else if (drain || !main_vld) begin
                main_vld_n = accept;
                if (accept)
                    main_n = new_e;
            end else if (accept) begin
                skid_n     = new_e;
                skid_vld_n = 1'b1;
            end
        end else begin
            if (accept) begin
                main_vld_n = 1'b1;
                main_n     = new_e;
            end else if (drain) begin
                main_vld_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            main_vld <= main_vld_n;
            skid_vld <= skid_vld_n;
            main_q   <= main_n;
            skid_q   <= skid_n;
            rdy_q    <= ~skid_vld_n;
        end
    end

    assign bus.dec_valid = main_vld;
    assign bus.opcode    = main_q.dec.opcode;
    assign bus.imm       = main_q.dec.imm;
    assign bus.inst_type = main_q.dec.inst_type;
    assign bus.rd        = main_q.dec.rd;
    assign bus.rs1       = main_q.dec.rs1;
    assign bus.rs2       = main_q.dec.rs2;
    assign bus.funct     = main_q.dec.funct;
    assign bus.illegal   = main_q.dec.illegal;
    assign bus.pc_out    = main_q.pc;
endmodule

// File: tb/tb_idecoder_pipe.sv
// Scoreboard bench for idecoder_pipe: both SKID variants, decode table, backpressure, flush, reset.
module tb_idecoder_pipe;
    import idecoder_pipe_pkg::*;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [31:0] imm;
        logic [3:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  funct;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b1;
    logic        d_valid = 1'b0, d_flush = 1'b0, d_ready = 1'b1;
    logic [31:0] d_inst = '0, d_pc = '0;

    idecoder_pipe_if #(.PC_WIDTH(32)) b1 ();
    idecoder_pipe_if #(.PC_WIDTH(32)) b0 ();

    assign b1.inst_valid = d_valid & sel;
    assign b0.inst_valid = d_valid & ~sel;
    assign b1.inst = d_inst;
    assign b0.inst = d_inst;
    assign b1.pc_in = d_pc;
    assign b0.pc_in = d_pc;
    assign b1.flush = d_flush;
    assign b0.flush = d_flush;
    assign b1.dec_ready = sel ? d_ready : 1'b1;
    assign b0.dec_ready = sel ? 1'b1 : d_ready;

    idecoder_pipe #(.PC_WIDTH(32), .SKID(1'b1)) u_skid (.clk(clk), .rst(rst), .bus(b1));
    idecoder_pipe #(.PC_WIDTH(32), .SKID(1'b0)) u_reg  (.clk(clk), .rst(rst), .bus(b0));

    always #5 clk = ~clk;

    exp_t mon;
    logic mon_vld, mon_rdy;
    always_comb begin
        if (sel) begin
            mon     = {b1.opcode, b1.imm, b1.inst_type, b1.rd, b1.rs1, b1.rs2, b1.funct, b1.illegal, b1.pc_out};
            mon_vld = b1.dec_valid;
            mon_rdy = b1.inst_ready;
        end else begin
            mon     = {b0.opcode, b0.imm, b0.inst_type, b0.rd, b0.rs1, b0.rs2, b0.funct, b0.illegal, b0.pc_out};
            mon_vld = b0.dec_valid;
            mon_rdy = b0.inst_ready;
        end
    end

    exp_t        sb[$];
    exp_t        cur, prev;
    logic        prev_stall = 1'b0;
    logic        seen_rdy;
    int          errs = 0, checks = 0, n_acc = 0, n_out = 0;
    logic [31:0] t_inst[16];
    exp_t        t_exp[16];

    function automatic exp_t mk(input logic [6:0] op, input logic [31:0] imm, input logic [3:0] typ,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] funct, input logic ill);
        exp_t e;
        e = {op, imm, typ, rd, rs1, rs2, funct, ill, 32'h0};
        return e;
    endfunction

    // Sample on the falling edge, then let the rising edge commit the beats seen.
    task automatic cycle();
        logic in_beat, out_beat, fl;
        exp_t e;
        @(negedge clk);
        in_beat  = d_valid && mon_rdy && !d_flush;
        out_beat = mon_vld && d_ready;
        fl       = d_flush;
        seen_rdy = mon_rdy;
        if (prev_stall) begin
            checks++;
            if (mon !== prev) begin
                errs++;
                $display("FAIL hold: got %h want %h", mon, prev);
            end
        end
        prev_stall = mon_vld && !d_ready && !fl;
        prev       = mon;
        if (out_beat) begin
            n_out++;
            checks++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_output: got %h want none", mon);
            end else begin
                e = sb.pop_front();
                if (mon !== e) begin
                    errs++;
                    $display("FAIL decode_out: got %h want %h", mon, e);
                end
            end
        end
        if (fl)
            sb.delete();
        else if (in_beat) begin
            sb.push_back(cur);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int idx, input logic [31:0] pc);
        int start;
        start   = n_acc;
        d_valid = 1'b1;
        d_inst  = t_inst[idx];
        d_pc    = pc;
        cur     = t_exp[idx];
        cur.pc  = pc;
        for (int k = 0; k < 20 && n_acc == start; k++)
            cycle();
        checks++;
        if (n_acc == start) begin
            errs++;
            $display("FAIL accept_timeout: got 0 accepts want 1 (entry %0d)", idx);
        end
    endtask

    task automatic build_table();
        t_inst[0]  = 32'hFFB10093; t_exp[0]  = mk(7'h13, 32'hFFFFFFFB, INST_TYPE_INT_IMM, 5'd1, 5'd2, 5'd0, FUNCT_ADD, 1'b0);
        t_inst[1]  = 32'h40725193; t_exp[1]  = mk(7'h13, 32'd7, INST_TYPE_INT_IMM, 5'd3, 5'd4, 5'd0, FUNCT_SRA, 1'b0);
        t_inst[2]  = 32'h00832283; t_exp[2]  = mk(7'h03, 32'd8, INST_TYPE_LOAD, 5'd5, 5'd6, 5'd0, FUNCT_MEM_WORD, 1'b0);
        t_inst[3]  = 32'h00000000; t_exp[3]  = mk(7'h00, 32'd0, INST_TYPE_ILLEGAL, 5'd0, 5'd0, 5'd0, FUNCT_NONE, 1'b1);
        t_inst[4]  = 32'h02000033; t_exp[4]  = mk(7'h33, 32'd0, INST_TYPE_ILLEGAL, 5'd0, 5'd0, 5'd0, FUNCT_NONE, 1'b1);
        t_inst[5]  = 32'h409403B3; t_exp[5]  = mk(7'h33, 32'd0, INST_TYPE_INT_REG, 5'd7, 5'd8, 5'd9, FUNCT_SUB, 1'b0);
        t_inst[6]  = 32'h12345537; t_exp[6]  = mk(7'h37, 32'h12345000, INST_TYPE_IMM, 5'd10, 5'd0, 5'd0, FUNCT_NONE, 1'b0);
        t_inst[7]  = 32'hFE208CE3; t_exp[7]  = mk(7'h63, 32'hFFFFFFF8, INST_TYPE_BRANCH, 5'd0, 5'd1, 5'd2, FUNCT_EQ, 1'b0);
        t_inst[8]  = 32'h00532623; t_exp[8]  = mk(7'h23, 32'd12, INST_TYPE_STORE, 5'd0, 5'd6, 5'd5, FUNCT_MEM_WORD, 1'b0);
        t_inst[9]  = 32'h00000073; t_exp[9]  = mk(7'h73, 32'd0, INST_TYPE_SYSTEM, 5'd0, 5'd0, 5'd0, FUNCT_ECALL, 1'b0);
        t_inst[10] = 32'h00100073; t_exp[10] = mk(7'h73, 32'd0, INST_TYPE_SYSTEM, 5'd0, 5'd0, 5'd0, FUNCT_EBREAK, 1'b0);
        t_inst[11] = 32'h010000EF; t_exp[11] = mk(7'h6F, 32'd16, INST_TYPE_JAL, 5'd1, 5'd0, 5'd0, FUNCT_NONE, 1'b0);
        t_inst[12] = 32'h40209093; t_exp[12] = mk(7'h13, 32'd0, INST_TYPE_ILLEGAL, 5'd0, 5'd0, 5'd0, FUNCT_NONE, 1'b1);
        t_inst[13] = 32'h0001C103; t_exp[13] = mk(7'h03, 32'd0, INST_TYPE_LOAD, 5'd2, 5'd3, 5'd0, FUNCT_MEM_BYTEU, 1'b0);
        t_inst[14] = 32'h0FF0000F; t_exp[14] = mk(7'h0F, 32'd0, INST_TYPE_FENCE, 5'd0, 5'd0, 5'd0, FUNCT_NONE, 1'b0);
        t_inst[15] = 32'h00009067; t_exp[15] = mk(7'h67, 32'd0, INST_TYPE_ILLEGAL, 5'd0, 5'd0, 5'd0, FUNCT_NONE, 1'b1);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (b1.dec_valid !== 1'b0 || b0.dec_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_dec_valid: got %b/%b want 0/0", b1.dec_valid, b0.dec_valid);
        end
        checks++;
        if (b1.inst_ready !== 1'b0 || b0.inst_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_inst_ready: got %b/%b want 0/0", b1.inst_ready, b0.inst_ready);
        end
        checks++;
        if (mon !== '0) begin
            errs++;
            $display("FAIL reset_payload: got %h want 0", mon);
        end
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (b1.inst_ready !== 1'b1 || b0.inst_ready !== 1'b1) begin
            errs++;
            $display("FAIL first_ready: got %b/%b want 1/1", b1.inst_ready, b0.inst_ready);
        end
    endtask

    task automatic test_decode();
        sel     = 1'b1;
        d_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            offer(i, 32'h1000 + 32'(i * 4));
            d_valid = 1'b0;
            cycle();
            checks++;
            if (sb.size() != 0) begin
                errs++;
                $display("FAIL latency: got %0d pending want 0 (entry %0d)", sb.size(), i);
            end
        end
    endtask

    task automatic test_back_to_back(input logic s);
        int idx, acc0, out0;
        logic [31:0] pc;
        int order[4] = '{0, 1, 2, 5};
        sel  = s;
        idx  = 0;
        acc0 = n_acc;
        out0 = n_out;
        for (int c = 0; c < 40 && (n_out - out0) < 4; c++) begin
            d_valid = (idx < 4);
            if (idx < 4) begin
                pc     = 32'h2000 + 32'(idx * 4);
                d_inst = t_inst[order[idx]];
                d_pc   = pc;
                cur    = t_exp[order[idx]];
                cur.pc = pc;
            end
            d_ready = (c >= 3);
            cycle();
            if (c == 2) begin
                checks++;
                if (seen_rdy !== 1'b0 || (n_acc - acc0) != (s ? 2 : 1)) begin
                    errs++;
                    $display("FAIL ready_fall: got ready=%b accepts=%0d want ready=0 accepts=%0d",
                             seen_rdy, n_acc - acc0, s ? 2 : 1);
                end
            end
            idx = n_acc - acc0;
        end
        d_valid = 1'b0;
        checks++;
        if ((n_out - out0) != 4 || sb.size() != 0) begin
            errs++;
            $display("FAIL drain_count: got %0d outputs %0d pending want 4 outputs 0 pending",
                     n_out - out0, sb.size());
        end
    endtask

    task automatic test_throughput(input logic s);
        int acc0;
        sel     = s;
        d_ready = 1'b1;
        acc0    = n_acc;
        for (int c = 0; c < 6; c++) begin
            d_valid = 1'b1;
            d_inst  = t_inst[6 + c];
            d_pc    = 32'h3000 + 32'(c * 4);
            cur     = t_exp[6 + c];
            cur.pc  = d_pc;
            cycle();
        end
        d_valid = 1'b0;
        cycle();
        checks++;
        if ((n_acc - acc0) != 6 || sb.size() != 0) begin
            errs++;
            $display("FAIL throughput: got %0d accepts %0d pending want 6 accepts 0 pending",
                     n_acc - acc0, sb.size());
        end
    endtask

    task automatic test_flush();
        int out0;
        sel     = 1'b1;
        d_ready = 1'b0;
        offer(6, 32'h4000);
        offer(7, 32'h4004);
        d_inst  = t_inst[8];
        d_pc    = 32'h4008;
        cur     = t_exp[8];
        cur.pc  = 32'h4008;
        d_flush = 1'b1;
        cycle();
        d_flush = 1'b0;
        d_valid = 1'b0;
        checks++;
        if (b1.dec_valid !== 1'b0 || b1.inst_ready !== 1'b1) begin
            errs++;
            $display("FAIL flush_state: got valid=%b ready=%b want valid=0 ready=1",
                     b1.dec_valid, b1.inst_ready);
        end
        d_ready = 1'b1;
        out0    = n_out;
        offer(9, 32'h400C);
        d_valid = 1'b0;
        cycle();
        cycle();
        checks++;
        if ((n_out - out0) != 1 || sb.size() != 0) begin
            errs++;
            $display("FAIL flush_after: got %0d outputs %0d pending want 1 output 0 pending",
                     n_out - out0, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        sel     = 1'b1;
        d_ready = 1'b0;
        offer(0, 32'h5000);
        offer(1, 32'h5004);
        d_valid = 1'b0;
        rst     = 1'b1;
        #1;
        checks++;
        if (b1.dec_valid !== 1'b0 || b1.inst_ready !== 1'b0 || mon !== '0) begin
            errs++;
            $display("FAIL reset_mid: got valid=%b ready=%b payload=%h want 0/0/0",
                     b1.dec_valid, b1.inst_ready, mon);
        end
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (b1.inst_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_mid_ready: got %b want 1", b1.inst_ready);
        end
        d_ready = 1'b1;
        offer(2, 32'h5008);
        d_valid = 1'b0;
        cycle();
        checks++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL reset_mid_resume: got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        build_table();
        test_reset();
        test_decode();
        test_back_to_back(1'b1);
        test_back_to_back(1'b0);
        test_throughput(1'b1);
        test_throughput(1'b0);
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
